seat_reset_ctrl: RTL and testbench
==================================

# seat_reset_ctrl

Schedules the daily seat-occupancy clear for the seating system. The operator programs a reset time with three buttons. The block drives that value onto the timer's `reset_time` input and watches the timer's `rst_timer` match flag and `time_out` bus. When the programmed minute is reached, it sweeps a clear command across every seat index over a valid/ready handshake to the seat-state store.

## Interface
- `NUM_SEATS`, default 32: number of seats cleared per sweep; must be ≤ 2^`SEAT_W`.
- `SEAT_W`, default 5: width of the seat index.

- `clk`  in  1: system clock; all state on rising edge.
- `rst`  in  1: one clock; reset is asynchronous and active-high.
- `set_btn`  in  1: single-cycle pulse, debounced upstream; advances the programming mode.
- `inc_btn`  in  1: single-cycle pulse; increments the field being edited.
- `cancel_btn`  in  1: single-cycle pulse; leaves programming or disarms.
- `time_in`  in  11: timer `time_out`, {hour[10:6], min[5:0]}.
- `rst_match`  in  1: timer `rst_timer` (timer hour equals `reset_time` hour).
- `reset_time`  out  11: programmed time {hour, min}; drives the timer.
- `armed`  out  1: high in ARMED and CLEARING.
- `seat_clr_valid`  out  1: clear request for `seat_clr_idx`.
- `seat_clr_idx`  out  `SEAT_W`: seat index being cleared.
- `seat_clr_ready`  in  1: the store accepts the request when `valid & ready`.
- `sweep_done`  out  1: one-cycle pulse after the last seat is accepted.

## Operation
- States: IDLE, SET_HOUR, SET_MIN, ARMED, CLEARING.
- IDLE:
  - `set_btn` → SET_HOUR.
  - `inc_btn` and `cancel_btn` are ignored.
- SET_HOUR:
  - `inc_btn` increments the hour; 23 wraps to 0.
  - `set_btn` → SET_MIN.
  - `cancel_btn` → IDLE; the value is kept.
- SET_MIN:
  - `inc_btn` increments the minute; 59 wraps to 0.
  - `set_btn` → ARMED.
  - `cancel_btn` → IDLE.
- ARMED:
  - Trigger condition `hit = rst_match & (time_in[5:0] == reset_time[5:0])`.
  - A rising edge of `hit` → CLEARING with idx 0.
  - `prev_hit` is registered every cycle in all states. Entering ARMED while `hit` is already 1 does not fire; the next firing is on the next rising edge.
  - `set_btn` → SET_HOUR (re-program).
  - `cancel_btn` → IDLE.
  - A button event has priority over a same-cycle trigger.
- CLEARING:
  - `seat_clr_valid` = 1, held until accepted.
  - On `valid & ready`, idx increments.
  - Acceptance at idx `NUM_SEATS-1` ends the sweep: valid drops, `sweep_done` pulses, and the next state follows the Configuration section.
  - All buttons are ignored until the sweep ends.
  - `reset_time` is frozen.
- `ready` while valid is low has no effect. `ready` low stalls idx indefinitely with no timeout.
- Simultaneous `set_btn` and `cancel_btn`: cancel wins. `inc_btn` together with either: inc is ignored.
- Hour and minute fields never take illegal values: no 24+ hours, no 60+ minutes.

## Timing
- Reset values:
  - state IDLE
  - `reset_time` = 11'd0 (00:00)
  - `armed` = 0
  - `seat_clr_valid` = 0
  - `seat_clr_idx` = 0
  - `sweep_done` = 0
  - `prev_hit` = 0
- Button pulse at edge N: `reset_time`/state change is visible after edge N (one-cycle latency).
- `hit` rising at cycle N (`prev_hit` = 0): `seat_clr_valid` = 1, idx = 0 from cycle N+1.
- Accept at cycle M: idx+1 visible at M+1. Final accept at M: `valid` = 0 and `sweep_done` = 1 at M+1 for exactly one cycle.
- Minimum sweep length is `NUM_SEATS` cycles with `ready` tied high.
- `rst` asserted mid-sweep clears immediately (asynchronously) to the reset values. No partial-sweep resume and no `sweep_done`.

## Configuration
- `SEAT_RESET_ONESHOT_EN`:
  - Defined: after a sweep, state → IDLE and `armed` = 0. The operator must re-arm via the button sequence.
  - Undefined (default): after a sweep, state → ARMED and the block fires again the next day.
  - `reset_time` is retained in both cases.

## Test plan
- Reset, then set, inc×7, set, inc×30, set → `reset_time` = {5'd7, 6'd30}, `armed` = 1, no valid.
- In SET_HOUR from 23 → inc → hour 0. In SET_MIN from 59 → inc → minute 0. Cancel in SET_MIN → IDLE, `armed` = 0, value kept.
- Armed at 07:30, drive `rst_match` = 1 with `time_in` 07:29 then 07:30, `ready` = 1 → valid from the cycle after 07:30 appears; idx 0..31 on consecutive cycles; `sweep_done` one cycle after idx 31. Default build returns to ARMED; `SEAT_RESET_ONESHOT_EN` build returns to IDLE.
- Hold `ready` = 0 for 5 cycles at idx 3 → idx stays 3 and valid stays 1. Press `set_btn`/`cancel_btn` during the sweep → ignored; sweep completes.
- Arm while `hit` is already 1 → no sweep. Drop `hit` for 1 cycle then raise it → sweep starts. `set_btn` in the same cycle as the `hit` edge → SET_HOUR, no sweep.
- Assert `rst` at idx 10 → valid, idx, `armed` and `reset_time` go to 0 asynchronously; no `sweep_done`.

Source files
------------

// File: rtl/seat_reset_ctrl.sv
// Daily seat-occupancy clear scheduler: button-programmed reset time, minute-edge trigger, seat sweep.
// Optional build macro SEAT_RESET_ONESHOT_EN: disarm after each sweep instead of re-arming for the next day.
module seat_reset_ctrl #(
    parameter int NUM_SEATS = 32,
    parameter int SEAT_W    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_btn,
    input  logic              inc_btn,
    input  logic              cancel_btn,
    input  logic [10:0]       time_in,
    input  logic              rst_match,
    output logic [10:0]       reset_time,
    output logic              armed,
    output logic              seat_clr_valid,
    output logic [SEAT_W-1:0] seat_clr_idx,
    input  logic              seat_clr_ready,
    output logic              sweep_done
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SET_HOUR = 3'd1;
    localparam logic [2:0] S_SET_MIN  = 3'd2;
    localparam logic [2:0] S_ARMED    = 3'd3;
    localparam logic [2:0] S_CLEARING = 3'd4;

    localparam logic [SEAT_W-1:0] LAST_IDX = SEAT_W'(NUM_SEATS - 1);
    localparam logic [SEAT_W-1:0] IDX_ONE  = SEAT_W'(1);

`ifdef SEAT_RESET_ONESHOT_EN
    localparam logic [2:0] S_AFTER_SWEEP = S_IDLE;
`else
    localparam logic [2:0] S_AFTER_SWEEP = S_ARMED;
`endif

    logic [2:0]        state_q, state_d;
    logic [4:0]        hour_q, hour_d;
    logic [5:0]        min_q, min_d;
    logic [SEAT_W-1:0] idx_q, idx_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              armed_q, armed_d;
    logic              prev_hit_q, prev_hit_d;
    logic              hit_s;
    logic              time_hour_unused_s;

    // The hour comparison is already folded into rst_match by the timer.
    assign time_hour_unused_s = ^time_in[10:6];

    // Trigger detect: hour match from the timer plus our own minute compare.
    always_comb begin
        hit_s = rst_match & (time_in[5:0] == min_q);
    end

    // Next-state logic for the programming FSM and the seat sweep.
    always_comb begin
        state_d    = state_q;
        hour_d     = hour_q;
        min_d      = min_q;
        idx_d      = idx_q;
        valid_d    = valid_q;
        done_d     = 1'b0;
        prev_hit_d = hit_s;
        case (state_q)
            S_IDLE: begin
                if (set_btn && !cancel_btn) begin
                    state_d = S_SET_HOUR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SET_HOUR: begin
                if (cancel_btn) begin
                    state_d = S_IDLE;
                end else if (set_btn) begin
                    state_d = S_SET_MIN;
                end else if (inc_btn) begin
                    hour_d = (hour_q >= 5'd23) ? 5'd0 : hour_q + 5'd1;
                end else begin
                    state_d = S_SET_HOUR;
                end
            end
            S_SET_MIN: begin
                if (cancel_btn) begin
                    state_d = S_IDLE;
                end else if (set_btn) begin
                    state_d = S_ARMED;
                end else if (inc_btn) begin
                    min_d = (min_q >= 6'd59) ? 6'd0 : min_q + 6'd1;
                end else begin
                    state_d = S_SET_MIN;
                end
            end
            S_ARMED: begin
                // Buttons outrank a same-cycle trigger edge.
                if (cancel_btn) begin
                    state_d = S_IDLE;
                end else if (set_btn) begin
                    state_d = S_SET_HOUR;
                end else if (hit_s && !prev_hit_q) begin
                    state_d = S_CLEARING;
                    idx_d   = {SEAT_W{1'b0}};
                    valid_d = 1'b1;
                end else begin
                    state_d = S_ARMED;
                end
            end
            S_CLEARING: begin
                if (valid_q && seat_clr_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_AFTER_SWEEP;
                        idx_d   = {SEAT_W{1'b0}};
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end else begin
                    state_d = S_CLEARING;
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = {SEAT_W{1'b0}};
                valid_d = 1'b0;
            end
        endcase
        armed_d = (state_d == S_ARMED) || (state_d == S_CLEARING);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            hour_q     <= 5'd0;
            min_q      <= 6'd0;
            idx_q      <= {SEAT_W{1'b0}};
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            armed_q    <= 1'b0;
            prev_hit_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hour_q     <= hour_d;
            min_q      <= min_d;
            idx_q      <= idx_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            armed_q    <= armed_d;
            prev_hit_q <= prev_hit_d;
        end
    end

    assign reset_time     = {hour_q, min_q};
    assign armed          = armed_q;
    assign seat_clr_valid = valid_q;
    assign seat_clr_idx   = idx_q;
    assign sweep_done     = done_q;

endmodule

// File: tb/tb_seat_reset_ctrl.sv
// Scoreboard bench for seat_reset_ctrl: directed button/timer vectors, monitor checks every accepted clear.
module tb_seat_reset_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        set_btn = 1'b0;
    logic        inc_btn = 1'b0;
    logic        cancel_btn = 1'b0;
    logic [10:0] time_in = 11'd0;
    logic        rst_match = 1'b0;
    logic [10:0] reset_time;
    logic        armed;
    logic        seat_clr_valid;
    logic [4:0]  seat_clr_idx;
    logic        seat_clr_ready = 1'b0;
    logic        sweep_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc_cyc = 0;
    int exp_idx_q[$];
    int exp_done_q[$];

    localparam logic [10:0] T0730 = {5'd7, 6'd30};
    localparam logic [10:0] T0729 = {5'd7, 6'd29};

`ifdef SEAT_RESET_ONESHOT_EN
    localparam logic EXP_ARMED_AFTER = 1'b0;
`else
    localparam logic EXP_ARMED_AFTER = 1'b1;
`endif

    seat_reset_ctrl #(.NUM_SEATS(32), .SEAT_W(5)) dut (
        .clk(clk), .rst(rst), .set_btn(set_btn), .inc_btn(inc_btn), .cancel_btn(cancel_btn),
        .time_in(time_in), .rst_match(rst_match), .reset_time(reset_time), .armed(armed),
        .seat_clr_valid(seat_clr_valid), .seat_clr_idx(seat_clr_idx),
        .seat_clr_ready(seat_clr_ready), .sweep_done(sweep_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted clear and every done pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (seat_clr_valid && seat_clr_ready) begin
                if (exp_idx_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_accept idx=%0d expected=none", seat_clr_idx);
                end else begin
                    chk("accept_idx", seat_clr_idx, exp_idx_q.pop_front());
                end
                last_acc_cyc = cyc;
            end
            if (sweep_done) begin
                if (exp_done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_sweep_done actual=1 expected=0");
                end else begin
                    void'(exp_done_q.pop_front());
                    chk("done_cycle", cyc, last_acc_cyc + 1);
                    chk("done_valid_low", seat_clr_valid, 0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic s, input logic i, input logic c);
        set_btn = s; inc_btn = i; cancel_btn = c;
        tick();
        set_btn = 1'b0; inc_btn = 1'b0; cancel_btn = 1'b0;
    endtask

    task automatic press_n(input logic s, input logic i, input int n);
        for (int k = 0; k < n; k++) press(s, i, 1'b0);
    endtask

    // Re-enter ARMED from IDLE or ARMED, optionally with hit already high.
    task automatic arm(input logic hit_on);
        press(1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        if (hit_on) begin
            time_in = T0730; rst_match = 1'b1;
            tick();
        end
        press(1'b1, 1'b0, 1'b0);
        chk("arm_armed", armed, 1);
    endtask

    // Produce a hit rising edge and queue the full expected sweep.
    task automatic fire();
        for (int k = 0; k < 32; k++) exp_idx_q.push_back(k);
        exp_done_q.push_back(1);
        time_in = T0730; rst_match = 1'b1;
        tick();
        chk("fire_valid", seat_clr_valid, 1);
        chk("fire_idx", seat_clr_idx, 0);
    endtask

    task automatic finish_sweep();
        int n;
        n = 0;
        while (!sweep_done && n < 200) begin
            tick();
            n++;
        end
        chk("sweep_done_seen", sweep_done, 1);
        chk("post_sweep_armed", armed, EXP_ARMED_AFTER);
        tick();
        chk("done_one_cycle", sweep_done, 0);
        rst_match = 1'b0;
        tick();
    endtask

    initial begin
        #2;
        chk("rst_reset_time", reset_time, 0);
        chk("rst_armed", armed, 0);
        chk("rst_valid", seat_clr_valid, 0);
        chk("rst_idx", seat_clr_idx, 0);
        chk("rst_done", sweep_done, 0);
        @(posedge clk); #1; rst = 1'b0;

        // Basic programming to 07:30.
        press(1'b0, 1'b1, 1'b0);
        chk("idle_inc_ignored", reset_time, 0);
        press(1'b1, 1'b0, 1'b0);
        press_n(1'b0, 1'b1, 7);
        press(1'b1, 1'b0, 1'b0);
        press_n(1'b0, 1'b1, 30);
        press(1'b1, 1'b0, 1'b0);
        chk("prog_time", reset_time, T0730);
        chk("prog_armed", armed, 1);
        chk("prog_no_valid", seat_clr_valid, 0);

        // Wrap behaviour and cancel.
        press(1'b1, 1'b0, 1'b0);
        chk("reprog_armed_low", armed, 0);
        press_n(1'b0, 1'b1, 16);
        chk("hour_23", reset_time, {5'd23, 6'd30});
        press(1'b0, 1'b1, 1'b0);
        chk("hour_wrap", reset_time, {5'd0, 6'd30});
        press(1'b1, 1'b0, 1'b0);
        press_n(1'b0, 1'b1, 29);
        chk("min_59", reset_time, {5'd0, 6'd59});
        press(1'b0, 1'b1, 1'b0);
        chk("min_wrap", reset_time, 0);
        press(1'b0, 1'b0, 1'b1);
        chk("cancel_armed", armed, 0);
        chk("cancel_kept", reset_time, 0);

        // set+cancel together -> IDLE, so a following inc is ignored.
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b1);
        press(1'b0, 1'b1, 1'b0);
        chk("set_cancel_cancel_wins", reset_time, 0);
        // inc+set together in SET_HOUR -> SET_MIN with hour untouched.
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b1, 1'b0);
        chk("inc_with_set_ignored", reset_time, 0);
        press(1'b0, 1'b1, 1'b0);
        chk("now_in_set_min", reset_time, {5'd0, 6'd1});
        press(1'b0, 1'b0, 1'b1);

        press(1'b1, 1'b0, 1'b0);
        press_n(1'b0, 1'b1, 7);
        press(1'b1, 1'b0, 1'b0);
        press_n(1'b0, 1'b1, 29);
        press(1'b1, 1'b0, 1'b0);
        chk("reprog_time", reset_time, T0730);

        // Sweep 1: ready high, exact timing.
        seat_clr_ready = 1'b1;
        time_in = T0729; rst_match = 1'b1;
        tick();
        chk("no_fire_0729", seat_clr_valid, 0);
        fire();
        for (int k = 0; k < 31; k++) tick();
        chk("idx31", seat_clr_idx, 31);
        chk("idx31_valid", seat_clr_valid, 1);
        tick();
        chk("s1_done", sweep_done, 1);
        chk("s1_valid_low", seat_clr_valid, 0);
        finish_sweep();

        // Sweep 2: stall at idx 3 and buttons during the sweep.
        arm(1'b0);
        time_in = T0729; rst_match = 1'b1;
        tick();
        fire();
        tick(); tick(); tick();
        chk("stall_idx_start", seat_clr_idx, 3);
        seat_clr_ready = 1'b0;
        press(1'b1, 1'b0, 1'b1);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        tick(); tick();
        chk("stall_idx", seat_clr_idx, 3);
        chk("stall_valid", seat_clr_valid, 1);
        chk("stall_armed", armed, 1);
        chk("stall_time_frozen", reset_time, T0730);
        seat_clr_ready = 1'b1;
        finish_sweep();

        // Arm with hit already high: no sweep until a fresh edge.
        arm(1'b1);
        for (int k = 0; k < 5; k++) tick();
        chk("armed_at_hit_no_fire", seat_clr_valid, 0);
        rst_match = 1'b0;
        tick();
        fire();
        finish_sweep();

        // Button on the same edge as the trigger wins.
        arm(1'b0);
        time_in = T0730;
        set_btn = 1'b1; rst_match = 1'b1;
        tick();
        set_btn = 1'b0;
        chk("btn_prio_armed", armed, 0);
        chk("btn_prio_valid", seat_clr_valid, 0);
        tick(); tick();
        chk("btn_prio_still_no_valid", seat_clr_valid, 0);
        press(1'b0, 1'b0, 1'b1);
        rst_match = 1'b0;

        // Async reset at idx 10.
        arm(1'b0);
        fire();
        for (int k = 0; k < 10; k++) tick();
        chk("pre_rst_idx", seat_clr_idx, 10);
        #1 rst = 1'b1;
        #1;
        chk("arst_valid", seat_clr_valid, 0);
        chk("arst_idx", seat_clr_idx, 0);
        chk("arst_armed", armed, 0);
        chk("arst_time", reset_time, 0);
        chk("arst_remaining", exp_idx_q.size(), 22);
        exp_idx_q.delete();
        exp_done_q.delete();
        rst_match = 1'b0;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 40; k++) tick();
        chk("post_rst_no_valid", seat_clr_valid, 0);
        chk("post_rst_done_low", sweep_done, 0);

        chk("scoreboard_idx_empty", exp_idx_q.size(), 0);
        chk("scoreboard_done_empty", exp_done_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
